// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit_pkg
//  Purpose  : Shared types and constants for the instruction fetch stage:
//             FSM state encoding, instruction width and default reset PC.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    // Width of an instruction word and of a fetch address.
    localparam int INST_W = 32;

    // Default fetch PC after reset.
    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Low address bits cleared to force word alignment.
    localparam logic [INST_W-1:0] C_WORD_MASK = ~32'h0000_0003;

    // Fetch sequencer states.
    //   IF_IDLE  : no request outstanding, may issue.
    //   IF_WAIT  : one request outstanding, its response is wanted.
    //   IF_STALE : one request outstanding, its response will be dropped.
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_WAIT  = 2'd1,
        IF_STALE = 2'd2
    } if_state_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
        return addr & C_WORD_MASK;
    endfunction

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue
//  Purpose  : Circular FIFO of {pc, instruction} pairs between the fetch
//             sequencer and the decoder. Supports push, pop and flush, with
//             a global enable that freezes all state.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH_W = 2,
    parameter int DATA_W  = INST_W
) (
    input  logic               clk_in,
    input  logic               rst_in,      // synchronous, active low
    input  logic               en,          // 0 freezes the queue
    input  logic               push,
    input  logic [DATA_W-1:0]  push_pc,
    input  logic [DATA_W-1:0]  push_inst,
    input  logic               pop,
    input  logic               flush,       // discards every entry
    output logic [DEPTH_W:0]   count,
    output logic [DATA_W-1:0]  head_pc,
    output logic [DATA_W-1:0]  head_inst,
    output logic               empty,
    output logic               full
);

    localparam int               C_DEPTH     = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] C_DEPTH_CNT = (DEPTH_W + 1)'(C_DEPTH);

    logic [DATA_W-1:0]  r_pc_mem   [C_DEPTH];
    logic [DATA_W-1:0]  r_inst_mem [C_DEPTH];
    logic [DEPTH_W-1:0] r_head;
    logic [DEPTH_W-1:0] r_tail;
    logic [DEPTH_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH_CNT);

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign w_do_push = push && (!w_full || pop);
    assign w_do_pop  = pop && !w_empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (en) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_do_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_do_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry storage; contents are don't-care until written, reads are masked when empty.
    always_ff @(posedge clk_in) begin
        if (en && !flush && w_do_push) begin
            r_pc_mem[r_tail]   <= push_pc;
            r_inst_mem[r_tail] <= push_inst;
        end
    end

    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign head_pc   = w_empty ? '0 : r_pc_mem[r_head];
    assign head_inst = w_empty ? '0 : r_inst_mem[r_head];

endmodule : inst_queue
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : Fetch stage. Holds the fetch PC, keeps at most one icache read
//             outstanding, queues returned instructions with their PCs and
//             presents the queue head to the decoder. Redirects on a taken
//             branch or a misprediction, flushing younger work.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                IQ_DEPTH_W = 2,
    parameter logic [INST_W-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,             // synchronous, active low
    input  logic              rdy_in,             // 0 freezes all state

    output logic              icache_req_valid,
    output logic [INST_W-1:0] icache_req_addr,
    input  logic              icache_req_ready,
    input  logic              icache_resp_valid,
    input  logic [INST_W-1:0] icache_resp_data,

    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [INST_W-1:0] inst_pc,
    input  logic              inst_ready,

    input  logic              need_branch,
    input  logic [INST_W-1:0] branch_addr,
    input  logic              predict_fail,
    input  logic [INST_W-1:0] fail_addr
);

    localparam logic [IQ_DEPTH_W:0] C_DEPTH_CNT = (IQ_DEPTH_W + 1)'(1 << IQ_DEPTH_W);

    // Sequencer registers.
    if_state_t         r_state;
    logic [INST_W-1:0] r_pc;
    logic [INST_W-1:0] r_req_pc;

    // Queue interface.
    logic [IQ_DEPTH_W:0] w_q_count;
    logic [INST_W-1:0]   w_q_head_pc;
    logic [INST_W-1:0]   w_q_head_inst;
    logic                w_q_empty;
    logic                w_q_full;

    // Control decode.
    logic                w_pop;
    logic                w_take_br;
    logic                w_redirect;
    logic [INST_W-1:0]   w_redirect_pc;
    logic [IQ_DEPTH_W:0] w_inflight;
    logic [IQ_DEPTH_W:0] w_slots_used;
    logic                w_has_space;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_push;

    assign w_pop     = inst_valid && inst_ready;
    assign w_take_br = need_branch && w_pop;

    // Misprediction outranks a predicted-taken branch in the same cycle.
    assign w_redirect    = predict_fail || w_take_br;
    assign w_redirect_pc = word_align(predict_fail ? fail_addr : branch_addr);

    // The outstanding request owns a queue slot, so the queue can never overflow.
    assign w_inflight   = (r_state != IF_IDLE) ? (IQ_DEPTH_W + 1)'(1) : '0;
    assign w_slots_used = w_q_count + w_inflight;
    assign w_has_space  = (w_slots_used < C_DEPTH_CNT) && !w_q_full;

    // No request while in reset or while a redirect is retargeting the PC.
    assign w_req_valid = rst_in && (r_state == IF_IDLE) && w_has_space && !w_redirect;
    assign w_req_fire  = rdy_in && w_req_valid && icache_req_ready;

    // A response arriving with a redirect belongs to the old path and is dropped.
    assign w_push = (r_state == IF_WAIT) && icache_resp_valid && !w_redirect;

    // Fetch sequencer: request issue, response tracking and PC update.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= IF_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (rdy_in) begin
            case (r_state)
                IF_IDLE: begin
                    if (w_req_fire) begin
                        r_state  <= IF_WAIT;
                        r_req_pc <= word_align(r_pc);
                    end
                end
                IF_WAIT: begin
                    // The response retires the request even when it is discarded.
                    if (icache_resp_valid) begin
                        r_state <= IF_IDLE;
                    end else if (w_redirect) begin
                        r_state <= IF_STALE;
                    end
                end
                IF_STALE: begin
                    if (icache_resp_valid) begin
                        r_state <= IF_IDLE;
                    end
                end
                default: r_state <= IF_IDLE;
            endcase

            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    inst_queue #(
        .DEPTH_W (IQ_DEPTH_W),
        .DATA_W  (INST_W)
    ) u_inst_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .push      (w_push),
        .push_pc   (r_req_pc),
        .push_inst (icache_resp_data),
        .pop       (w_pop),
        .flush     (w_redirect),
        .count     (w_q_count),
        .head_pc   (w_q_head_pc),
        .head_inst (w_q_head_inst),
        .empty     (w_q_empty),
        .full      (w_q_full)
    );

    assign icache_req_valid = w_req_valid;
    assign icache_req_addr  = word_align(r_pc);

    assign inst_valid = !w_q_empty;
    assign inst_data  = w_q_head_inst;
    assign inst_pc    = w_q_head_pc;

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Purpose  : Directed self-checking bench for inst_fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        need_branch;
    logic [31:0] branch_addr;
    logic        predict_fail;
    logic [31:0] fail_addr;

    int n_assert = 0;
    int n_fail   = 0;

    inst_fetch_unit #(
        .IQ_DEPTH_W (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .inst_valid        (inst_valid),
        .inst_data         (inst_data),
        .inst_pc           (inst_pc),
        .inst_ready        (inst_ready),
        .need_branch       (need_branch),
        .branch_addr       (branch_addr),
        .predict_fail      (predict_fail),
        .fail_addr         (fail_addr)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at exp_addr, answer it one cycle later.
    task automatic fetch_one(input logic [31:0] exp_addr);
        #1;
        chk("fetch_req_valid", 32'(icache_req_valid), 32'd1);
        chk("fetch_req_addr", icache_req_addr, exp_addr);
        tick();
        chk("fetch_wait_no_req", 32'(icache_req_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_data  = exp_addr ^ KEY;
        tick();
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'h0;
    endtask

    initial begin
        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        icache_req_ready  = 1'b1;
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'h0;
        inst_ready        = 1'b0;
        need_branch       = 1'b0;
        branch_addr       = 32'h0;
        predict_fail      = 1'b0;
        fail_addr         = 32'h0;

        // ---- reset ----
        tick();
        tick();
        chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst_in = 1'b1;

        // ---- stream ----
        fetch_one(32'h0);
        chk("stream_head_valid", 32'(inst_valid), 32'd1);
        chk("stream_head_pc0", inst_pc, 32'h0);
        chk("stream_head_data0", inst_data, 32'hA5A5_A5A5);
        fetch_one(32'h4);
        icache_req_ready = 1'b0;
        inst_ready       = 1'b1;
        #1;
        chk("stream_pop_pc0", inst_pc, 32'h0);
        tick();
        chk("stream_pop_pc4", inst_pc, 32'h4);
        chk("stream_pop_data4", inst_data, 32'hA5A5_A5A1);
        tick();
        inst_ready       = 1'b0;
        icache_req_ready = 1'b1;
        #1;
        chk("stream_empty_valid", 32'(inst_valid), 32'd0);
        chk("stream_empty_data", inst_data, 32'h0);

        // ---- queue full ----
        fetch_one(32'h8);
        fetch_one(32'hC);
        fetch_one(32'h10);
        fetch_one(32'h14);
        #1;
        chk("full_no_req", 32'(icache_req_valid), 32'd0);
        tick();
        chk("full_no_req_hold", 32'(icache_req_valid), 32'd0);
        chk("full_head_pc", inst_pc, 32'h8);
        inst_ready = 1'b1;
        #1;
        chk("full_pop_cycle_no_req", 32'(icache_req_valid), 32'd0);
        tick();
        inst_ready = 1'b0;
        #1;
        chk("full_after_pop_req", 32'(icache_req_valid), 32'd1);
        chk("full_after_pop_addr", icache_req_addr, 32'h18);
        chk("full_after_pop_head", inst_pc, 32'hC);
        tick();
        chk("full_one_req_wait", 32'(icache_req_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h18 ^ KEY;
        tick();
        icache_resp_valid = 1'b0;
        #1;
        chk("full_again_no_req", 32'(icache_req_valid), 32'd0);
        tick();
        chk("full_again_no_req2", 32'(icache_req_valid), 32'd0);

        // ---- misprediction flushes the whole queue, restart at 0 ----
        predict_fail = 1'b1;
        fail_addr    = 32'h0;
        #1;
        chk("mp_cycle_no_req", 32'(icache_req_valid), 32'd0);
        tick();
        predict_fail = 1'b0;
        #1;
        chk("mp_queue_empty", 32'(inst_valid), 32'd0);
        chk("mp_req_valid", 32'(icache_req_valid), 32'd1);
        chk("mp_req_addr", icache_req_addr, 32'h0);

        // ---- taken branch with 2 queued behind head and 1 in WAIT ----
        fetch_one(32'h0);
        fetch_one(32'h4);
        icache_req_ready = 1'b0;
        inst_ready       = 1'b1;
        tick();
        tick();
        inst_ready       = 1'b0;
        icache_req_ready = 1'b1;
        fetch_one(32'h8);
        fetch_one(32'hC);
        fetch_one(32'h10);
        #1;
        chk("br_req_addr_14", icache_req_addr, 32'h14);
        tick();
        inst_ready  = 1'b1;
        need_branch = 1'b1;
        branch_addr = 32'h100;
        #1;
        chk("br_head_pc", inst_pc, 32'h8);
        chk("br_head_data", inst_data, 32'h8 ^ KEY);
        tick();
        inst_ready  = 1'b0;
        need_branch = 1'b0;
        #1;
        chk("br_queue_empty", 32'(inst_valid), 32'd0);
        chk("br_stale_no_req", 32'(icache_req_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h14 ^ KEY;
        tick();
        icache_resp_valid = 1'b0;
        #1;
        chk("br_stale_dropped", 32'(inst_valid), 32'd0);
        chk("br_new_req_valid", 32'(icache_req_valid), 32'd1);
        chk("br_new_req_addr", icache_req_addr, 32'h100);

        // ---- mispredict and branch together, request pending in IDLE ----
        fetch_one(32'h100);
        fetch_one(32'h104);
        inst_ready   = 1'b1;
        need_branch  = 1'b1;
        branch_addr  = 32'h200;
        predict_fail = 1'b1;
        fail_addr    = 32'h40;
        #1;
        chk("mpbr_req_suppressed", 32'(icache_req_valid), 32'd0);
        tick();
        inst_ready   = 1'b0;
        need_branch  = 1'b0;
        predict_fail = 1'b0;
        #1;
        chk("mpbr_queue_empty", 32'(inst_valid), 32'd0);
        chk("mpbr_req_valid", 32'(icache_req_valid), 32'd1);
        chk("mpbr_req_addr", icache_req_addr, 32'h40);

        // ---- redirect coincident with response ----
        tick();
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h40 ^ KEY;
        predict_fail      = 1'b1;
        fail_addr         = 32'h82;
        tick();
        icache_resp_valid = 1'b0;
        predict_fail      = 1'b0;
        #1;
        chk("coinc_dropped", 32'(inst_valid), 32'd0);
        chk("coinc_req_valid", 32'(icache_req_valid), 32'd1);
        chk("coinc_req_addr", icache_req_addr, 32'h80);

        // ---- rdy_in stall during WAIT ----
        fetch_one(32'h80);
        #1;
        chk("stall_pre_addr", icache_req_addr, 32'h84);
        tick();
        rdy_in     = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_inst_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst_pc", inst_pc, 32'h80);
            chk("stall_inst_data", inst_data, 32'h80 ^ KEY);
            chk("stall_req_valid", 32'(icache_req_valid), 32'd0);
            tick();
        end
        rdy_in            = 1'b1;
        inst_ready        = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h84 ^ KEY;
        tick();
        icache_resp_valid = 1'b0;
        #1;
        chk("stall_head_kept", inst_pc, 32'h80);
        chk("stall_resume_req", 32'(icache_req_valid), 32'd1);
        chk("stall_resume_addr", icache_req_addr, 32'h88);
        icache_req_ready = 1'b0;
        inst_ready       = 1'b1;
        tick();
        inst_ready       = 1'b0;
        icache_req_ready = 1'b1;
        #1;
        chk("stall_second_pc", inst_pc, 32'h84);
        chk("stall_second_data", inst_data, 32'h84 ^ KEY);

        // ---- reset during WAIT ----
        tick();
        chk("rstw_in_wait", 32'(icache_req_valid), 32'd0);
        rst_in = 1'b0;
        tick();
        chk("rstw_inst_valid", 32'(inst_valid), 32'd0);
        chk("rstw_inst_pc", inst_pc, 32'h0);
        chk("rstw_inst_data", inst_data, 32'h0);
        chk("rstw_req_valid", 32'(icache_req_valid), 32'd0);
        rst_in = 1'b1;
        #1;
        chk("rstw_post_req_valid", 32'(icache_req_valid), 32'd1);
        chk("rstw_post_req_addr", icache_req_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the branch predictor and decoder.
- Holds the fetch PC and issues one outstanding 32-bit instruction read at a time to the icache.
- Buffers returned instructions with their PCs in a small FIFO and hands the head to the decoder over a valid/ready handshake.
- Redirects on a predicted-taken branch (need_branch/branch_addr) and on a misprediction (predict_fail/fail_addr), flushing younger work.

Parameters:
- IQ_DEPTH_W, 2, log2 of instruction-queue depth (depth = 1 << IQ_DEPTH_W).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_in  in  1  system clock, all state on rising edge.
- rst_in  in  1  synchronous, active-low reset (0 = reset).
- rdy_in  in  1  global enable; 0 freezes all state.
- icache_req_valid  out  1  read request valid.
- icache_req_addr  out  32  word-aligned fetch address.
- icache_req_ready  in  1  icache accepts the request this cycle.
- icache_resp_valid  in  1  one-cycle pulse, instruction data valid.
- icache_resp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid to decoder.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_ready  in  1  decoder consumes head this cycle.
- need_branch  in  1  predictor says the instruction popped this cycle is taken.
- branch_addr  in  32  predicted target.
- predict_fail  in  1  earlier prediction wrong; full flush.
- fail_addr  in  32  correct restart PC.

Behaviour:
- Reset (rst_in==0 at posedge): pc=RESET_PC, state=IDLE, queue empty (count=0, head=tail=0). Outputs: icache_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- rdy_in==0: no register changes; the icache is frozen by the same signal, so no resp pulse is presented.
- FSM states:
  - IDLE: icache_req_valid = (count < depth) && !predict_fail && !take_br, with icache_req_addr = {pc[31:2],2'b00}. On valid&&ready: go to WAIT and set pc = pc+4 (32-bit wrap).
  - WAIT: on icache_resp_valid, push {pc_of_req, data} and go to IDLE. Keep a req_pc register for the PC of the outstanding request.
  - STALE: entered when a redirect hits while in WAIT. On icache_resp_valid, discard the data and go to IDLE. A request is never issued from STALE.
- Space check counts the outstanding slot: issue only if count + (state!=IDLE) < depth. The FIFO therefore never overflows.
- Pop: when inst_valid && inst_ready, head advances with modulo-depth wrap. Simultaneous push and pop leaves count unchanged.
- take_br = need_branch && inst_valid && inst_ready. need_branch is ignored when no pop occurs.
- Redirect priority is predict_fail > take_br. Either one:
  - sets pc = {target[31:2],2'b00};
  - empties the queue (remaining entries after the pop for take_br; all entries including head for predict_fail);
  - changes WAIT to STALE;
  - blocks any request issue and any push that cycle.
- A response arriving in the same cycle as a redirect is discarded. The FSM goes to IDLE (not STALE), since the outstanding request is retired by that response.
- Redirect in IDLE with a request handshake pending that cycle: the request is suppressed (valid forced 0), so nothing goes stale.
- inst_valid = (count != 0), driven combinationally from registered count. inst_data/inst_pc read the head entry; both are 0 when empty.
- Latency: redirect at cycle N, new-target request at N+1 (IDLE case). Minimum fetch-to-decoder time is resp cycle + 1.

Decomposition:
- Shared package holds the FSM state encoding (IF_IDLE=2'd0, IF_WAIT=2'd1, IF_STALE=2'd2), INST_W=32, and RESET_PC default.
- One natural sub-module: inst_queue. It is a parameterised circular FIFO of {pc,inst} with push, pop and flush, and exposes count, head data and empty/full.

Test Plan:
- Reset then stream: rst_in=0 for 2 cycles, then 1; icache ready, resp 1 cycle after accept with data = addr^32'hA5A5A5A5. Required: requests to 0x0,0x4,0x8…; decoder sees (pc,inst) pairs in order with matching data.
- Queue full: hold inst_ready=0. Required: exactly 4 entries accepted and icache_req_valid stays 0. One pop gives exactly one new request.
- Taken branch: pop pc=0x8 with need_branch=1, branch_addr=0x100 while 2 entries are queued and 1 request is in WAIT. Required: queue empties and the stale response is dropped. The next request goes to 0x100 and no instruction from 0xC/0x10 reaches the decoder.
- Mispredict vs branch in the same cycle: predict_fail=1 with fail_addr=0x40 and need_branch=1 with branch_addr=0x200. Required: head is also flushed and the next fetch is 0x40.
- Redirect coincident with resp: flush in the same cycle as icache_resp_valid. Required: data dropped, state=IDLE, and a new request is issued the next cycle.
- rdy_in low mid-WAIT for 5 cycles, plus rst_in=0 during WAIT. Required: the stall leaves all outputs and state unchanged; the reset returns pc=0, queue empty and inst_valid=0.
